// File: rtl/cell_bist_ctrl.sv
// BIST sequencer for one 2-input combinational cell: sweeps all four input vectors PASSES times,
// samples dut_y SETTLE+1 cycles after each vector is applied and records mismatches against a captured truth table.
module cell_bist_ctrl #(
    parameter int SETTLE = 2,
    parameter int PASSES = 4,
    parameter int CNTW   = 8
) (
    input  logic            CLK,
    input  logic            R,
    input  logic            start,
    input  logic            abort,
    input  logic [3:0]      truth,
    output logic            dut_a,
    output logic            dut_b,
    input  logic            dut_y,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [CNTW-1:0] fail_cnt,
    output logic [3:0]      fail_mask,
    output logic [1:0]      first_fail
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_WAIT,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [CNTW-1:0] CNT_MAX    = '1;
    localparam logic [7:0]      LAST_SWEEP = 8'(PASSES - 1);
    localparam logic [3:0]      SETTLE_LD  = 4'(SETTLE);

    state_t     state;
    logic [3:0] truth_q;
    logic [1:0] vec;
    logic [7:0] sweep;
    logic [3:0] settle_cnt;
    logic [1:0] vec_nxt;
    logic       mismatch;

    assign vec_nxt  = vec + 2'd1;
    assign mismatch = (dut_y != truth_q[vec]);

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            state      <= S_IDLE;
            truth_q    <= '0;
            vec        <= '0;
            sweep      <= '0;
            settle_cnt <= '0;
            dut_a      <= 1'b0;
            dut_b      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_cnt   <= '0;
            fail_mask  <= '0;
            first_fail <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    dut_a <= 1'b0;
                    dut_b <= 1'b0;
                    if (start) begin
                        truth_q    <= truth;
                        fail_cnt   <= '0;
                        fail_mask  <= '0;
                        first_fail <= '0;
                        pass       <= 1'b0;
                        vec        <= '0;
                        sweep      <= '0;
                        busy       <= 1'b1;
                        state      <= S_APPLY;
                    end
                end
                S_APPLY: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        dut_a <= 1'b0;
                        dut_b <= 1'b0;
                    end else begin
                        settle_cnt <= SETTLE_LD;
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        dut_a <= 1'b0;
                        dut_b <= 1'b0;
                    end else if (settle_cnt <= 4'd1) begin
                        state <= S_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                S_SAMPLE: begin
                    if (abort) begin
                        // the compare of this cycle is dropped together with the run
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        dut_a <= 1'b0;
                        dut_b <= 1'b0;
                    end else begin
                        if (mismatch) begin
                            if (fail_cnt != CNT_MAX) begin
                                fail_cnt <= fail_cnt + CNTW'(1);
                            end
                            fail_mask[vec] <= 1'b1;
                            if (fail_cnt == '0) begin
                                first_fail <= vec;
                            end
                        end
                        if (vec != 2'd3) begin
                            vec   <= vec_nxt;
                            dut_a <= vec_nxt[1];
                            dut_b <= vec_nxt[0];
                            state <= S_APPLY;
                        end else if (sweep != LAST_SWEEP) begin
                            vec   <= '0;
                            sweep <= sweep + 8'd1;
                            dut_a <= 1'b0;
                            dut_b <= 1'b0;
                            state <= S_APPLY;
                        end else begin
                            // the final sample also decides pass, so fold it in here
                            pass  <= (fail_cnt == '0) && !mismatch;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            dut_a <= 1'b0;
                            dut_b <= 1'b0;
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cell_bist_ctrl.sv
// Bench for cell_bist_ctrl: three differently parameterised instances driven by a delayed-cell model,
// checked cycle by cycle against a sample-schedule reference computed from the timing rules.
module tb_cell_bist_ctrl;

    typedef struct packed {
        logic [7:0] cnt;
        logic [3:0] mask;
        logic [1:0] first;
        logic       pass;
    } res_t;

    logic       CLK;
    logic       R;
    logic [2:0] start;
    logic [2:0] abort;
    logic [3:0] truth;
    wire  [2:0] a_o, b_o, busy_o, done_o, pass_o;
    logic [2:0] y_i;
    wire  [7:0] cnt0, cnt1;
    wire  [1:0] cnt2;
    wire  [3:0] mask0, mask1, mask2;
    wire  [1:0] ff0, ff1, ff2;

    logic [3:0] cell_f;
    int         cell_d;
    logic [7:0] pipe [3];
    int         checks = 0;
    int         errors = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // cell model: truth function cell_f with a response delay of cell_d cycles
    always @(posedge CLK) begin
        for (int i = 0; i < 3; i++) pipe[i] <= {pipe[i][6:0], cell_f[{a_o[i], b_o[i]}]};
    end

    always_comb begin
        y_i = '0;
        for (int i = 0; i < 3; i++) begin
            if (cell_d == 0) y_i[i] = cell_f[{a_o[i], b_o[i]}];
            else             y_i[i] = pipe[i][(cell_d - 1) & 7];
        end
    end

    cell_bist_ctrl #(.SETTLE(2), .PASSES(4), .CNTW(8)) u0 (
        .CLK(CLK), .R(R), .start(start[0]), .abort(abort[0]), .truth(truth),
        .dut_a(a_o[0]), .dut_b(b_o[0]), .dut_y(y_i[0]), .busy(busy_o[0]), .done(done_o[0]),
        .pass(pass_o[0]), .fail_cnt(cnt0), .fail_mask(mask0), .first_fail(ff0));

    cell_bist_ctrl #(.SETTLE(3), .PASSES(2), .CNTW(8)) u1 (
        .CLK(CLK), .R(R), .start(start[1]), .abort(abort[1]), .truth(truth),
        .dut_a(a_o[1]), .dut_b(b_o[1]), .dut_y(y_i[1]), .busy(busy_o[1]), .done(done_o[1]),
        .pass(pass_o[1]), .fail_cnt(cnt1), .fail_mask(mask1), .first_fail(ff1));

    cell_bist_ctrl #(.SETTLE(1), .PASSES(3), .CNTW(2)) u2 (
        .CLK(CLK), .R(R), .start(start[2]), .abort(abort[2]), .truth(truth),
        .dut_a(a_o[2]), .dut_b(b_o[2]), .dut_y(y_i[2]), .busy(busy_o[2]), .done(done_o[2]),
        .pass(pass_o[2]), .fail_cnt(cnt2), .fail_mask(mask2), .first_fail(ff2));

    function automatic int p_settle(int i);
        return (i == 0) ? 2 : (i == 1) ? 3 : 1;
    endfunction
    function automatic int p_passes(int i);
        return (i == 0) ? 4 : (i == 1) ? 2 : 3;
    endfunction
    function automatic int p_cntw(int i);
        return (i == 2) ? 2 : 8;
    endfunction
    function automatic int p_total(int i);
        return 4 * p_passes(i) * (p_settle(i) + 2);
    endfunction

    function automatic logic [7:0] obs_cnt(int i);
        case (i)
            0:       return cnt0;
            1:       return cnt1;
            default: return {6'd0, cnt2};
        endcase
    endfunction
    function automatic logic [3:0] obs_mask(int i);
        case (i)
            0:       return mask0;
            1:       return mask1;
            default: return mask2;
        endcase
    endfunction
    function automatic logic [1:0] obs_ff(int i);
        case (i)
            0:       return ff0;
            1:       return ff1;
            default: return ff2;
        endcase
    endfunction

    // vector on the cell inputs c cycles after the first APPLY (zeros outside the run)
    function automatic int vec_at(int i, int c);
        int per;
        per = p_settle(i) + 2;
        if (c < 0 || c >= p_total(i)) return 0;
        return (c / per) % 4;
    endfunction

    // expected results when only samples taken before cycle 'limit' count
    function automatic res_t model(int i, logic [3:0] tv, int limit);
        res_t r;
        int   n;
        int   sat;
        r   = '0;
        n   = 0;
        sat = (1 << p_cntw(i)) - 1;
        for (int j = 0; j < 4 * p_passes(i); j++) begin
            int   c;
            int   v;
            logic y;
            c = j * (p_settle(i) + 2) + p_settle(i) + 1;
            v = j % 4;
            if (c >= limit) break;
            y = cell_f[vec_at(i, c - cell_d)];
            if (y !== tv[v]) begin
                if (n == 0) r.first = 2'(v);
                n++;
                r.mask[v] = 1'b1;
            end
        end
        r.cnt  = 8'((n > sat) ? sat : n);
        r.pass = (limit >= p_total(i)) && (n == 0);
        return r;
    endfunction

    task automatic check(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[u%0d]: observed %0h expected %0h", tag, inst, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_cycle(input int i, input int c);
        int v;
        v = vec_at(i, c);
        check("busy", i, busy_o[i], c < p_total(i));
        check("done", i, done_o[i], c == p_total(i));
        check("dut_a", i, a_o[i], v[1]);
        check("dut_b", i, b_o[i], v[0]);
    endtask

    task automatic check_res(input int i, input res_t e);
        check("fail_cnt", i, obs_cnt(i), e.cnt);
        check("fail_mask", i, obs_mask(i), e.mask);
        check("first_fail", i, obs_ff(i), e.first);
        check("pass", i, pass_o[i], e.pass);
    endtask

    task automatic check_reset_vals(input string tag);
        for (int i = 0; i < 3; i++) begin
            check({tag, "_busy"}, i, busy_o[i], 0);
            check({tag, "_done"}, i, done_o[i], 0);
            check({tag, "_ab"}, i, {a_o[i], b_o[i]}, 0);
            check({tag, "_res"}, i, {obs_cnt(i), obs_mask(i), obs_ff(i), pass_o[i]}, 0);
        end
    endtask

    task automatic prepare(input logic [3:0] tv, input logic [3:0] f, input int d);
        cell_f = f;
        cell_d = d;
        truth  = tv;
        for (int k = 0; k < 8; k++) begin
            abort = 3'($urandom);
            step();
        end
        abort = '0;
    endtask

    task automatic run_full(input logic [3:0] tv, input logic [3:0] f, input int d);
        res_t exp [3];
        prepare(tv, f, d);
        for (int i = 0; i < 3; i++) exp[i] = model(i, tv, p_total(i));
        start = '1;
        step();
        start = '0;
        for (int c = 0; c <= 65; c++) begin
            for (int i = 0; i < 3; i++) begin
                check_cycle(i, c);
                if (c == p_total(i) || c == 65) check_res(i, exp[i]);
            end
            truth = 4'($urandom);
            start = (c >= 1 && c <= 30) ? 3'($urandom) : 3'b000;
            for (int i = 0; i < 3; i++) abort[i] = (c == p_total(i)) ? 1'($urandom) : 1'b0;
            step();
        end
        start = '0;
        abort = '0;
    endtask

    task automatic run_abort(input logic [3:0] tv, input logic [3:0] f, input int d, input int m, input int hold);
        res_t exp [3];
        prepare(tv, f, d);
        for (int i = 0; i < 3; i++) exp[i] = model(i, tv, m);
        start = '1;
        step();
        start = '0;
        for (int c = 0; c <= m; c++) begin
            for (int i = 0; i < 3; i++) check_cycle(i, c);
            truth = 4'($urandom);
            if (c == m) abort = '1;
            step();
        end
        abort = '0;
        for (int k = 0; k < hold; k++) begin
            for (int i = 0; i < 3; i++) begin
                check("abort_busy", i, busy_o[i], 0);
                check("abort_done", i, done_o[i], 0);
                check("abort_ab", i, {a_o[i], b_o[i]}, 0);
                check_res(i, exp[i]);
            end
            step();
        end
    endtask

    initial begin
        R      = 1'b1;
        start  = '0;
        abort  = '0;
        truth  = '0;
        cell_f = '0;
        cell_d = 0;

        #1 R = 1'b0;
        #1 check_reset_vals("reset_async");
        repeat (3) @(posedge CLK);
        #1 check_reset_vals("reset_held");
        #2 R = 1'b1;
        step();
        check_reset_vals("reset_idle");

        run_full(4'b0111, 4'b0111, 0);
        check("nand_pass", 0, pass_o[0], 1);
        check("nand_cnt", 0, cnt0, 0);
        check("nand_mask", 0, mask0, 0);

        run_full(4'b0111, 4'b1111, 0);
        check("stuck_cnt", 0, cnt0, 4);
        check("stuck_mask", 0, mask0, 4'b1000);
        check("stuck_ff", 0, ff0, 2'b11);
        check("stuck_pass", 0, pass_o[0], 0);

        run_full(4'b0111, 4'b1000, 0);
        check("sat_cnt", 2, cnt2, 3);
        check("sat_mask", 2, mask2, 4'b1111);
        check("sat_ff", 2, ff2, 0);
        check("sat_pass", 2, pass_o[2], 0);

        run_full(4'b0111, 4'b0111, 4);
        check("delay_s2_pass", 0, pass_o[0], 0);
        check("delay_s2_cnt_nz", 0, cnt0 != 8'd0, 1);
        check("delay_s3_pass", 1, pass_o[1], 1);
        check("delay_s3_cnt", 1, cnt1, 0);

        run_abort(4'b0111, 4'b1111, 0, 9, 70);
        check("abort_cnt_held", 0, cnt0, 0);
        run_full(4'b0111, 4'b1111, 0);
        check("rerun_cnt", 0, cnt0, 4);

        // async reset in WAIT of sweep 2, after an ignored start pulse
        prepare(4'b0111, 4'b0111, 2);
        start = '1;
        step();
        start = '0;
        for (int c = 0; c < 33; c++) begin
            for (int i = 0; i < 3; i++) check_cycle(i, c);
            start = (c == 5) ? 3'b111 : 3'b000;
            step();
        end
        check_cycle(0, 33);
        #2 R = 1'b0;
        #1 check_reset_vals("areset");
        #1 R = 1'b1;
        step();
        check_reset_vals("post_areset");

        for (int n = 0; n < 10; n++) begin
            logic [3:0] tv;
            logic [3:0] f;
            tv = 4'($urandom);
            f  = ($urandom_range(0, 2) == 0) ? tv : 4'($urandom);
            run_full(tv, f, $urandom_range(0, 5));
        end
        for (int n = 0; n < 4; n++) begin
            run_abort(4'($urandom), 4'($urandom), $urandom_range(0, 5), $urandom_range(0, 35), 3);
        end

        // start held through DONE is only taken in the following IDLE cycle
        prepare(4'b0111, 4'b0111, 0);
        start = 3'b001;
        step();
        start = '0;
        repeat (64) step();
        check("b2b_done", 0, done_o[0], 1);
        start = 3'b001;
        step();
        check("b2b_idle", 0, busy_o[0], 0);
        step();
        start = '0;
        check("b2b_accept", 0, busy_o[0], 1);
        repeat (63) step();
        check("b2b_busy_end", 0, busy_o[0], 1);
        step();
        check("b2b_done2", 0, done_o[0], 1);
        check("b2b_pass2", 0, pass_o[0], 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
